// File: rtl/mv_tile_controller.sv
// Matrix-vector tile sequencer: for each PE_NUMBER-wide tile of outputs it clears the PEs,
// streams N operand addresses, waits out the systolic skew, then drains A results to memory.

module mv_tile_lane #(
    parameter int            AW   = 10,
    parameter int            EW   = 18,
    parameter int            LANE = 0,
    parameter logic [AW-1:0] ZP   = '1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_i,
    input  logic [EW-1:0] row_base_i,
    input  logic [EW-1:0] act_i,
    output logic [AW-1:0] addr_o
);
    logic [AW-1:0] addr_q, addr_d;

    // Inactive columns of a partial tile read the zero address so their PEs accumulate nothing.
    always_comb begin
        addr_d = ZP;
        if (fetch_i && (EW'(LANE) < act_i))
            addr_d = AW'(row_base_i + EW'(LANE));
    end

    always_ff @(posedge clk) begin
        if (reset) addr_q <= ZP;
        else       addr_q <= addr_d;
    end

    assign addr_o = addr_q;
endmodule

module mv_tile_controller #(
    parameter int          ADDR_SIZE       = 10,
    parameter int          PE_NUMBER       = 64,
    parameter int          DIM_W           = 8,
    parameter logic [15:0] MEM_HEAD_ADDR   = 16'h000f,
    parameter logic [15:0] ZERO_POINT_ADDR = 16'hffff
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 csr_valid,
    input  logic [1:0]                           csr_addr,
    input  logic [DIM_W-1:0]                     csr_data,
    output logic                                 csr_ready,
    output logic                                 pe_clear,
    output logic                                 read,
    output logic [ADDR_SIZE-1:0]                 l_d_o_addr,
    output logic [PE_NUMBER-1:0][ADDR_SIZE-1:0]  pe_t_o_addr,
    output logic                                 w_en,
    output logic [ADDR_SIZE-1:0]                 w_addr,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);
    localparam int             AW     = ADDR_SIZE;
    localparam int             EW     = ADDR_SIZE + DIM_W;
    localparam int             CW     = DIM_W + 1;
    localparam logic [AW-1:0]  ZP     = AW'(ZERO_POINT_ADDR);
    localparam logic [EW-1:0]  ZP_E   = EW'(ZP);
    localparam logic [EW-1:0]  HEAD_E = EW'(AW'(MEM_HEAD_ADDR));
    localparam logic [EW-1:0]  PE_E   = EW'(PE_NUMBER);
    localparam logic [EW-1:0]  ONE_E  = EW'(1);
    localparam logic [EW-1:0]  TWO_E  = EW'(2);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_DRAIN, S_NEXT} state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   n_q, n_d, m_q, m_d, t_q, t_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               csr_ready_q, pe_clear_q, read_q, w_en_q, done_q;
    logic [AW-1:0]      w_addr_q, l_d_q;

    logic [EW-1:0]      n_e, m_e, cnt_e, out_base, tile_base, rem_e, act_e, row_base;
    logic               cfg_ok, last_tile, start, fetch_last, wait_last, drain_last;

    assign n_e       = EW'(n_q);
    assign m_e       = EW'(m_q);
    assign cnt_e     = EW'(cnt_q);
    assign out_base  = HEAD_E + n_e + n_e * m_e;
    assign tile_base = EW'(t_q) * PE_E;
    assign rem_e     = m_e - tile_base;
    assign act_e     = (rem_e < PE_E) ? rem_e : PE_E;
    assign last_tile = (tile_base + PE_E) >= m_e;
    assign row_base  = HEAD_E + n_e + cnt_e * m_e + tile_base;

    // The whole result block must end below the zero address, so no legal run ever wraps.
    assign cfg_ok     = (n_q != '0) && (m_q != '0) && ((out_base + m_e - ONE_E) < ZP_E);
    assign start      = csr_valid && csr_ready_q && (csr_addr == 2'd2) && csr_data[0];
    assign fetch_last = cnt_e == (n_e - ONE_E);
    assign wait_last  = cnt_e == (n_e + act_e - TWO_E);
    assign drain_last = cnt_e == (act_e - ONE_E);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        err_d   = err_q;
        n_d     = n_q;
        m_d     = m_q;
        if (csr_valid && csr_ready_q) begin
            if (csr_addr == 2'd0) n_d = csr_data;
            if (csr_addr == 2'd1) m_d = csr_data;
        end
        case (state_q)
            S_IDLE: if (start) begin
                if (cfg_ok) begin
                    state_d = S_CLEAR;
                    t_d     = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else begin
                    err_d   = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_FETCH: begin
                if (fetch_last) begin state_d = S_WAIT; cnt_d = '0; end
                else cnt_d = cnt_q + 1'b1;
            end
            S_WAIT: begin
                if (wait_last) begin state_d = S_DRAIN; cnt_d = '0; end
                else cnt_d = cnt_q + 1'b1;
            end
            S_DRAIN: begin
                if (drain_last) begin state_d = S_NEXT; cnt_d = '0; end
                else cnt_d = cnt_q + 1'b1;
            end
            S_NEXT: begin
                if (last_tile) begin state_d = S_IDLE; t_d = '0; end
                else begin state_d = S_CLEAR; t_d = t_q + 1'b1; end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every address-side output lags the state that produced it by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            m_q         <= '0;
            t_q         <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            csr_ready_q <= 1'b0;
            pe_clear_q  <= 1'b1;
            read_q      <= 1'b0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            l_d_q       <= ZP;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            m_q         <= m_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            csr_ready_q <= (state_d == S_IDLE);
            pe_clear_q  <= (state_q == S_CLEAR);
            read_q      <= (state_q == S_DRAIN);
            w_en_q      <= (state_q == S_DRAIN);
            if (state_q == S_DRAIN) w_addr_q <= AW'(out_base + tile_base + cnt_e);
            l_d_q       <= (state_q == S_FETCH) ? AW'(HEAD_E + cnt_e) : ZP;
            done_q      <= (state_q == S_NEXT) && last_tile;
        end
    end

    for (genvar i = 0; i < PE_NUMBER; i++) begin : g_lane
        mv_tile_lane #(.AW(AW), .EW(EW), .LANE(i), .ZP(ZP)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .fetch_i    (state_q == S_FETCH),
            .row_base_i (row_base),
            .act_i      (act_e),
            .addr_o     (pe_t_o_addr[i])
        );
    end

    assign csr_ready  = csr_ready_q;
    assign pe_clear   = pe_clear_q;
    assign read       = read_q;
    assign w_en       = w_en_q;
    assign w_addr     = w_addr_q;
    assign l_d_o_addr = l_d_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
endmodule
